// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory-access stage: big-endian byte/half/word loads and stores over a req/ack bus.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stall_o,
    output logic              bus_err_o,
    output logic              addr_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q, load_q, abort_q;
    logic [3:0]          sel_q, op_q;
    logic [1:0]          off_q;
    logic [DATA_W-1:0]   wdata_q, result_q;

    logic                is_mem, is_load, is_byte, is_half, is_word, misalign, at_limit;
    logic [3:0]          sel_next;
    logic [DATA_W-1:0]   wdata_next, load_ext;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;

    always_comb begin
        is_mem     = (op_i >= 4'd1) && (op_i <= 4'd8);
        is_load    = (op_i >= 4'd1) && (op_i <= 4'd5);
        is_byte    = (op_i == 4'd1) || (op_i == 4'd2) || (op_i == 4'd6);
        is_half    = (op_i == 4'd3) || (op_i == 4'd4) || (op_i == 4'd7);
        is_word    = (op_i == 4'd5) || (op_i == 4'd8);
        sel_next   = 4'b0000;
        wdata_next = reg2_i;
        if (is_byte) begin
            sel_next   = 4'b1000 >> addr_i[1:0];
            wdata_next = {4{reg2_i[7:0]}};
        end else if (is_half) begin
            sel_next   = addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_next = {2{reg2_i[15:0]}};
        end else if (is_word) begin
            sel_next   = 4'b1111;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misalign = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane extraction uses the offset and op captured at request time, not the live inputs.
    always_comb begin
        byte_v   = 8'(bus_rdata_i >> {~off_q, 3'b000});
        half_v   = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        case (op_q)
            4'd1:    load_ext = {{24{byte_v[7]}}, byte_v};
            4'd2:    load_ext = {24'd0, byte_v};
            4'd3:    load_ext = {{16{half_v[15]}}, half_v};
            4'd4:    load_ext = {16'd0, half_v};
            default: load_ext = bus_rdata_i;
        endcase
    end

    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            load_q   <= 1'b0;
            abort_q  <= 1'b0;
            sel_q    <= 4'b0000;
            op_q     <= 4'd0;
            off_q    <= 2'b00;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (is_mem && !misalign) begin
                    addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                    we_q    <= !is_load;
                    load_q  <= is_load;
                    sel_q   <= sel_next;
                    op_q    <= op_i;
                    off_q   <= addr_i[1:0];
                    wdata_q <= wdata_next;
                    cnt     <= '0;
                    abort_q <= 1'b0;
                end
                REQ: begin
                    if (bus_ack_i) result_q <= load_ext;
                    else if (at_limit) abort_q <= 1'b1;
                    else cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output mux and next state; outputs are held at zero while reset is asserted.
    always_comb begin
        state_next  = state;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = 4'b0000;
        bus_wdata_o = '0;
        stall_o     = 1'b0;
        bus_err_o   = 1'b0;
        addr_err_o  = 1'b0;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end else if (misalign) begin
                    wd_o       = wd_i;
                    wdata_o    = wdata_i;
                    addr_err_o = 1'b1;
                end else begin
                    stall_o    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall_o     = 1'b1;
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = addr_q;
                bus_sel_o   = sel_q;
                bus_wdata_o = wdata_q;
                if (bus_ack_i || at_limit) state_next = DONE;
            end
            DONE: begin
                wd_o       = wd_i;
                state_next = IDLE;
                if (abort_q) begin
                    bus_err_o = 1'b1;
                end else begin
                    wreg_o  = wreg_i;
                    wdata_o = load_q ? result_q : wdata_i;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            wd_o        = 5'd0;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'b0000;
            bus_wdata_o = '0;
            stall_o     = 1'b0;
            bus_err_o   = 1'b0;
            addr_err_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4; checks lanes, extension, stall length and abort.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o;
    logic [31:0] wdata_i, wdata_o, addr_i, reg2_i, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  op_i, bus_sel_o;
    logic        bus_req_o, bus_we_o, bus_ack_i, stall_o, bus_err_o, addr_err_o;

    int tests = 0;
    int fails = 0;

    int          stall_cnt, req_cnt;
    logic        done_seen, seen_we, done_wreg, done_err, done_aerr;
    logic [3:0]  seen_sel;
    logic [31:0] seen_addr, seen_wdata, done_wdata;
    logic [4:0]  done_wd;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .op_i(op_i),
        .addr_i(addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .addr_err_o(addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one op at a negedge, acks on REQ cycle index 'waits', and samples through DONE.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [31:0] rdata, input int waits, input bit give_ack);
        op_i = op; addr_i = addr; reg2_i = reg2; bus_rdata_i = rdata;
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hA5A5_0000;
        stall_cnt = 0; req_cnt = 0; done_seen = 1'b0;
        seen_sel = 4'h0; seen_addr = 32'h0; seen_wdata = 32'h0; seen_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!stall_o) begin
                done_seen  = 1'b1;
                done_wd    = wd_o;
                done_wreg  = wreg_o;
                done_wdata = wdata_o;
                done_err   = bus_err_o;
                done_aerr  = addr_err_o;
                op_i = 4'd0;
                break;
            end
            stall_cnt++;
            if (bus_req_o) begin
                seen_sel = bus_sel_o; seen_addr = bus_addr_o;
                seen_wdata = bus_wdata_o; seen_we = bus_we_o;
                bus_ack_i = give_ack && (req_cnt == waits);
                req_cnt++;
            end
            @(negedge clk);
            bus_ack_i = 1'b0;
        end
        checkOutput("done_reached", {31'd0, done_seen}, 32'd1);
        op_i = 4'd0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; op_i = 4'd0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        addr_i = 32'h0; reg2_i = 32'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_wd", {27'd0, wd_o}, 32'd0);
        checkOutput("rst_wreg", {31'd0, wreg_o}, 32'd0);
        checkOutput("rst_wdata", wdata_o, 32'd0);
        checkOutput("rst_stall_req", {30'd0, stall_o, bus_req_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Non-memory passthrough, including an out-of-range op code
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0000_1234; op_i = 4'd0;
        #1;
        checkOutput("none_wd", {27'd0, wd_o}, 32'd9);
        checkOutput("none_wdata", wdata_o, 32'h0000_1234);
        checkOutput("none_wreg_stall", {30'd0, wreg_o, stall_o}, 32'b10);
        op_i = 4'd12;
        #1;
        checkOutput("op12_passthru", {wdata_o[15:0], 11'd0, wd_o}, {16'h1234, 11'd0, 5'd9});
        checkOutput("op12_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);

        // LB at offset 01 with two wait states
        applyStimulus(4'd1, 32'h8000_0001, 32'h0, 32'h12F4_5678, 2, 1'b1);
        checkOutput("lb_sel", {28'd0, seen_sel}, 32'b0100);
        checkOutput("lb_addr", seen_addr, 32'h8000_0000);
        checkOutput("lb_stall", stall_cnt, 32'd4);
        checkOutput("lb_req", req_cnt, 32'd3);
        checkOutput("lb_wdata", done_wdata, 32'hFFFF_FFF4);
        checkOutput("lb_wreg_wd", {26'd0, done_wreg, done_wd}, {26'd0, 1'b1, 5'd7});
        checkOutput("lb_err", {31'd0, done_err}, 32'd0);

        // LHU, zero waits
        applyStimulus(4'd4, 32'h8000_0002, 32'h0, 32'hAAAA_8001, 0, 1'b1);
        checkOutput("lhu_sel", {28'd0, seen_sel}, 32'b0011);
        checkOutput("lhu_wdata", done_wdata, 32'h0000_8001);
        checkOutput("lhu_stall", stall_cnt, 32'd2);

        // LH upper half, sign-extended
        applyStimulus(4'd3, 32'h8000_0000, 32'h0, 32'h8001_7777, 1, 1'b1);
        checkOutput("lh_sel", {28'd0, seen_sel}, 32'b1100);
        checkOutput("lh_wdata", done_wdata, 32'hFFFF_8001);

        // SH at offset 00 uses the upper lanes; SH at offset 10 the lower lanes
        applyStimulus(4'd7, 32'h0000_0010, 32'h0000_BEEF, 32'h0, 0, 1'b1);
        checkOutput("sh_bwdata", seen_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_sel", {28'd0, seen_sel}, 32'b1100);
        checkOutput("sh_we", {31'd0, seen_we}, 32'd1);
        checkOutput("sh_addr", seen_addr, 32'h0000_0010);
        checkOutput("sh_done_wdata", done_wdata, 32'hA5A5_0000);
        applyStimulus(4'd7, 32'h0000_0012, 32'h1234_BEEF, 32'h0, 0, 1'b1);
        checkOutput("sh12_sel", {28'd0, seen_sel}, 32'b0011);
        checkOutput("sh12_addr", seen_addr, 32'h0000_0010);

        // SB at offset 11
        applyStimulus(4'd6, 32'h0000_0023, 32'hCAFE_0077, 32'h0, 1, 1'b1);
        checkOutput("sb_bwdata", seen_wdata, 32'h7777_7777);
        checkOutput("sb_sel", {28'd0, seen_sel}, 32'b0001);
        checkOutput("sb_addr", seen_addr, 32'h0000_0020);

        // LW without ack: four REQ cycles then abort
        applyStimulus(4'd5, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 1'b0);
        checkOutput("to_req", req_cnt, 32'd4);
        checkOutput("to_stall", stall_cnt, 32'd5);
        checkOutput("to_err", {31'd0, done_err}, 32'd1);
        checkOutput("to_wreg", {31'd0, done_wreg}, 32'd0);
        checkOutput("to_wdata", done_wdata, 32'd0);
        #1;
        checkOutput("to_err_pulse", {31'd0, bus_err_o}, 32'd0);
        @(negedge clk);

        // Ack on the last allowed REQ cycle is still a success
        applyStimulus(4'd5, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 3, 1'b1);
        checkOutput("lim_req", req_cnt, 32'd4);
        checkOutput("lim_err", {31'd0, done_err}, 32'd0);
        checkOutput("lim_wdata", done_wdata, 32'h1357_9BDF);

        // Misaligned word access
        applyStimulus(4'd5, 32'h0000_0006, 32'h0, 32'h2468_ACE0, 0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mis_aerr", {31'd0, done_aerr}, 32'd1);
        checkOutput("mis_req", req_cnt, 32'd0);
        checkOutput("mis_stall", stall_cnt, 32'd0);
        checkOutput("mis_wreg", {31'd0, done_wreg}, 32'd0);
`else
        checkOutput("mis_aerr", {31'd0, done_aerr}, 32'd0);
        checkOutput("mis_addr", seen_addr, 32'h0000_0004);
        checkOutput("mis_sel", {28'd0, seen_sel}, 32'b1111);
        checkOutput("mis_wdata", done_wdata, 32'h2468_ACE0);
`endif

        // Reset on the second REQ cycle, then a late ack
        op_i = 4'd5; addr_i = 32'h0000_0080; wd_i = 5'd7; wreg_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        checkOutput("rr_req1", {31'd0, bus_req_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1; op_i = 4'd0; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        @(negedge clk);
        #1;
        checkOutput("rr_outs", {bus_sel_o, bus_req_o, stall_o, wreg_o, bus_err_o, 3'd0, wd_o, 16'd0},
                    32'd0);
        checkOutput("rr_wdata", wdata_o | bus_addr_o, 32'd0);
        rst = 1'b0; bus_ack_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        checkOutput("rr_late_ack", {28'd0, bus_req_o, stall_o, wreg_o, bus_err_o}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rr_idle", {30'd0, bus_req_o, bus_err_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
